sdram_host_bist: RTL

//  Host-side built-in self-test engine that sits directly upstream of the SDRAM controller and drives its host interface.
//  On start it writes a data pattern over [addr_lo_i, addr_hi_i], then reads every word back and compares it.

---
 rtl/sdram_bist_pkg.sv | 17 +
 rtl/sdram_bist_pattern.sv | 50 +++++
 rtl/sdram_host_bist.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sdram_bist_pkg.sv
// Shared definitions for the SDRAM host BIST: FSM encoding and LFSR constants.
package sdram_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_GAP,
    S_RD_REQ,
    S_RD_GAP,
    S_DONE
  } state_t;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_POLY      = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;

endpackage

// File: rtl/sdram_bist_pattern.sv
// Test data generator. SDRAM_BIST_LFSR_EN selects a 16-bit Galois LFSR;
// otherwise the word is addr ^ seed and no LFSR state exists.
module sdram_bist_pattern
  import sdram_bist_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              reseed_i,
  input  logic              advance_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] word_o
);

  logic [DATA_W-1:0] seed_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     seed_q <= '0;
    else if (start_i) seed_q <= seed_i;
  end

`ifdef SDRAM_BIST_LFSR_EN
  logic [15:0] lfsr;
  logic        unused_ok;

  function automatic logic [15:0] fix_seed(input logic [15:0] s);
    return (s == 16'h0) ? LFSR_ZERO_SEED : s;
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       lfsr <= '0;
    else if (start_i)   lfsr <= fix_seed(seed_i[15:0]);
    else if (reseed_i)  lfsr <= fix_seed(seed_q[15:0]);
    else if (advance_i) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0);
  end

  assign word_o    = DATA_W'(lfsr);
  assign unused_ok = ^addr_i;
`else
  logic unused_ok;

  assign word_o    = addr_i[DATA_W-1:0] ^ seed_q;
  assign unused_ok = reseed_i ^ advance_i;
`endif

endmodule

// File: rtl/sdram_host_bist.sv
// Host-side SDRAM BIST: write pattern over [lo,hi], read back, compare, report.
// Optional build macro SDRAM_BIST_LFSR_EN switches the data pattern to an LFSR.
module sdram_host_bist
  import sdram_bist_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int ERR_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_lo_i,
  input  logic [ADDR_W-1:0] addr_hi_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic              busy_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [ERR_W-1:0]  err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic [DATA_W-1:0] first_err_exp_o,
  output logic [DATA_W-1:0] first_err_got_o,
  output logic              sd_wr_o,
  output logic              sd_rd_o,
  output logic [ADDR_W-1:0] sd_addr_o,
  output logic [DATA_W-1:0] sd_data_o,
  input  logic [DATA_W-1:0] sd_data_i,
  input  logic              sd_done_i
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, lo, hi;
  logic [TMO_W-1:0]  tmo;
  logic [DATA_W-1:0] word;
  logic              start_acc, range_err, at_hi, tmo_hit, miss;
  logic              pat_reseed, pat_advance;

  assign start_acc = start_i && (state == S_IDLE || state == S_DONE);
  assign range_err = addr_hi_i < addr_lo_i;
  assign at_hi     = addr == hi;
  assign tmo_hit   = !sd_done_i && (tmo == TMO_W'(TIMEOUT_CYC - 1));
  assign miss      = state == S_RD_REQ && sd_done_i && sd_data_i != word;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start_i) state_nx = range_err ? S_DONE : S_WR_REQ;
      S_WR_REQ: if (sd_done_i) state_nx = S_WR_GAP; else if (tmo_hit) state_nx = S_DONE;
      S_WR_GAP: state_nx = at_hi ? S_RD_REQ : S_WR_REQ;
      S_RD_REQ: if (sd_done_i) state_nx = S_RD_GAP; else if (tmo_hit) state_nx = S_DONE;
      S_RD_GAP: state_nx = at_hi ? S_DONE : S_RD_REQ;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = 1'b0;
    sd_wr_o     = 1'b0;
    sd_rd_o     = 1'b0;
    pat_reseed  = 1'b0;
    pat_advance = 1'b0;
    case (state)
      S_WR_REQ: begin busy_o = 1'b1; sd_wr_o = 1'b1; pat_advance = sd_done_i; end
      S_WR_GAP: begin busy_o = 1'b1; pat_reseed = at_hi; end
      S_RD_REQ: begin busy_o = 1'b1; sd_rd_o = 1'b1; pat_advance = sd_done_i; end
      S_RD_GAP: busy_o = 1'b1;
      default:  ;
    endcase
    sd_addr_o = (sd_wr_o || sd_rd_o) ? addr : '0;
    sd_data_o = sd_wr_o ? word : '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr <= '0; lo <= '0; hi <= '0; tmo <= '0;
      pass_o <= 1'b0; fail_o <= 1'b0; timeout_o <= 1'b0;
      err_count_o <= '0; first_err_addr_o <= '0;
      first_err_exp_o <= '0; first_err_got_o <= '0;
    end else begin
      tmo <= '0;
      case (state)
        S_IDLE, S_DONE: if (start_acc) begin
          lo <= addr_lo_i; hi <= addr_hi_i; addr <= addr_lo_i;
          pass_o <= 1'b0; fail_o <= range_err; timeout_o <= 1'b0;
          err_count_o <= '0; first_err_addr_o <= '0;
          first_err_exp_o <= '0; first_err_got_o <= '0;
        end
        S_WR_REQ, S_RD_REQ: begin
          tmo <= tmo + 1'b1;
          if (tmo_hit) begin fail_o <= 1'b1; timeout_o <= 1'b1; end
          if (miss) begin
            if (err_count_o != '1) err_count_o <= err_count_o + 1'b1;
            // err_count never returns to zero once set, so zero marks the first miss
            if (err_count_o == '0) begin
              first_err_addr_o <= addr;
              first_err_exp_o  <= word;
              first_err_got_o  <= sd_data_i;
            end
          end
        end
        S_WR_GAP: addr <= at_hi ? lo : addr + 1'b1;
        S_RD_GAP: begin
          if (!at_hi) addr <= addr + 1'b1;
          else begin
            pass_o <= err_count_o == '0;
            fail_o <= err_count_o != '0;
          end
        end
        default: ;
      endcase
    end
  end

  sdram_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pattern (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (start_acc),
    .reseed_i  (pat_reseed),
    .advance_i (pat_advance),
    .seed_i    (seed_i),
    .addr_i    (addr),
    .word_o    (word)
  );

endmodule
